// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port DataMemory between N SPCores.
// Each grant issues one 1-word load or store; busy stalls the Scheduler until all lanes finish.
module dmem_rr_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          req,
  input  logic [N_CORES-1:0]          we,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  input  logic [N_CORES*DATA_W-1:0]   wdata,
  output logic [N_CORES-1:0]          gnt,
  output logic [N_CORES*DATA_W-1:0]   rdata,
  output logic [N_CORES-1:0]          rvalid,
  output logic                        busy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [IW-1:0] LAST   = IW'(N_CORES - 1);
  localparam logic [IW:0]   NCORES = (IW+1)'(N_CORES);

  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, sel, pick;
  logic [IW:0]   cand;
  logic          found;

  // Search rr_ptr, rr_ptr+1, ... with wrap; first requester wins.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= NCORES) cand = cand - NCORES;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|req) state_nxt = ACCESS;
      ACCESS:    state_nxt = we[sel] ? IDLE : READ_WAIT;
      READ_WAIT: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      gnt[sel]  = 1'b1;
      mem_en    = 1'b1;
      mem_we    = we[sel];
      mem_addr  = addr[int'(sel)*ADDR_W +: ADDR_W];
      mem_wdata = wdata[int'(sel)*DATA_W +: DATA_W];
    end
  end

  assign busy = (|req) || (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      sel    <= '0;
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= '0;
      case (state)
        IDLE:      if (|req) sel <= pick;
        ACCESS:    rr_ptr <= (sel == LAST) ? '0 : sel + IW'(1);
        READ_WAIT: begin
          rdata[int'(sel)*DATA_W +: DATA_W] <= mem_rdata;
          rvalid[sel] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
